// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Conditions the MAX1000 user push-button for the 12 MHz fabric. The raw pin
//   is synchronized, normalized to "1 = pressed", and debounced separately for
//   press and release. State changes are reported as a stable level, one-cycle
//   press/release/long-press pulses and an 8-bit wrapping press counter.
//
// Ports
//   i_clk      12 MHz system clock
//   i_rst_n    asynchronous, active-low reset
//   i_btn      raw, asynchronous, bouncing button pin
//   o_level    debounced pressed level (1 = pressed)
//   o_press    one-cycle pulse on an accepted press
//   o_release  one-cycle pulse on an accepted release
//   o_long     one-cycle pulse after LONG_CYCLES of holding; once per press
//   o_count    accepted press count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic [7:0] o_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  // Pin level while the button is not pressed; the synchronizer resets to it
  // so that leaving reset never looks like a press edge.
  localparam logic REL_PIN = ACTIVE_LOW;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; sync_pipe[1] is the metastability-safe sample.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_pipe <= {REL_PIN, REL_PIN};
    else          sync_pipe <= {sync_pipe[0], i_btn};
  end

  // Normalized sample: 1 means pressed regardless of pin polarity.
  logic p;
  assign p = sync_pipe[1] ^ REL_PIN;

  // ---------------------------------------------------------------------------
  // Debounce / long-press FSM. All outputs are registered here.
  // ---------------------------------------------------------------------------
  state_t          state;
  logic [DW-1:0]   db_cnt;
  logic [LW-1:0]   long_cnt;
  logic            long_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      long_cnt  <= '0;
      long_done <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_count   <= 8'd0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;

      case (state)
        IDLE: begin
          if (p) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!p) begin
            // Bounce: drop back silently.
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state     <= PRESSED;
            db_cnt    <= '0;
            o_press   <= 1'b1;
            o_level   <= 1'b1;
            o_count   <= o_count + 8'd1;
            long_cnt  <= '0;
            long_done <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        PRESSED: begin
          // The hold timer runs on every PRESSED cycle, including the one that
          // first sees a release sample; it only freezes in RELEASE_WAIT.
          if (!long_done) begin
            if (long_cnt == LONG_LAST) begin
              o_long    <= 1'b1;
              long_done <= 1'b1;
            end else begin
              long_cnt <= long_cnt + 1'b1;
            end
          end
          if (!p) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (p) begin
            // Release glitch: resume holding, hold timer keeps its value.
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state     <= IDLE;
            db_cnt    <= '0;
            o_release <= 1'b1;
            o_level   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//   Directed and randomized stimulus for button_debounce with a run-length
//   reference model: the debounced level flips once the synchronized sample has
//   disagreed with it for DC+1 consecutive clocks, and the hold timer counts
//   pressed clocks that were not preceded by a released sample.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int DC = 4;
  localparam int LC = 10;
  localparam logic PIN_DN = 1'b0;   // pressed pin level (active low)
  localparam logic PIN_UP = 1'b1;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_btn;
  logic       o_level, o_press, o_release, o_long;
  logic [7:0] o_count;

  button_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES    (LC),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic m_h1, m_h2;         // raw pin samples from the last two edges
  logic m_lvl, m_ldone;
  int   m_run, m_held, m_cnt;
  logic ep, er, el;         // expected pulses for the current cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    assert (obs === expd) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  task automatic model_reset();
    m_h1 = PIN_UP; m_h2 = PIN_UP;
    m_lvl = 1'b0; m_ldone = 1'b0;
    m_run = 0; m_held = 0; m_cnt = 0;
    ep = 1'b0; er = 1'b0; el = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic p;
    int   run_before;
    ep = 1'b0; er = 1'b0; el = 1'b0;
    p = (m_h2 == PIN_DN);
    m_h2 = m_h1;
    m_h1 = b;
    run_before = m_run;
    if (p != m_lvl) m_run++;
    else            m_run = 0;
    if (m_lvl && !m_ldone && run_before == 0) begin
      m_held++;
      if (m_held == LC) begin
        el = 1'b1;
        m_ldone = 1'b1;
      end
    end
    if (m_run == DC + 1) begin
      m_run = 0;
      m_lvl = !m_lvl;
      if (m_lvl) begin
        ep = 1'b1;
        m_cnt = (m_cnt + 1) % 256;
        m_held = 0;
        m_ldone = 1'b0;
      end else begin
        er = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("level",   o_level,   m_lvl);
    chk("press",   o_press,   ep);
    chk("release", o_release, er);
    chk("long",    o_long,    el);
    chk("count",   o_count,   m_cnt);
    chk("excl", ($countones({o_press, o_release, o_long}) <= 1), 1);
  endtask

  // one clock with pin value b, then compare against the model
  task automatic step(input logic b);
    i_btn = b;
    @(posedge i_clk);
    model_edge(b);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_level", o_level, 0);
    chk("rst_count", o_count, 0);
    check_all();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int k, np, nr, nl;
    logic b;
    int len;

    i_btn   = PIN_UP;
    i_rst_n = 1'b0;
    #12;
    model_reset();
    check_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) step(PIN_UP);

    // clean press: latency, then long press and release
    k = 0;
    step(PIN_DN);
    while (!o_press && k < 20) begin step(PIN_DN); k++; end
    chk("press_lat", k, 6);
    chk("press_level", o_level, 1);
    chk("press_count", o_count, 1);
    k = 0; nl = 0;
    for (int i = 0; i < 20; i++) begin
      step(PIN_DN);
      if (o_long) begin nl++; k = i + 1; end
    end
    chk("long_lat", k, 10);
    chk("long_once", nl, 1);
    k = 0; nr = 0;
    step(PIN_UP);
    while (!o_release && k < 20) begin step(PIN_UP); k++; end
    chk("rel_lat", k, 6);
    chk("rel_level", o_level, 0);
    repeat (4) step(PIN_UP);

    // bounce: five short presses, then a held one
    do_reset();
    np = 0; nr = 0;
    for (int r = 0; r < 5; r++) begin
      repeat (3) begin step(PIN_DN); np += o_press; nr += o_release; end
      step(PIN_UP); np += o_press; nr += o_release;
    end
    repeat (12) begin step(PIN_DN); np += o_press; nr += o_release; end
    chk("bounce_press", np, 1);
    chk("bounce_count", o_count, 1);
    chk("bounce_rel", nr, 0);
    repeat (12) step(PIN_UP);

    // release glitch while pressed delays the long pulse by its length
    k = 0;
    while (!o_press && k < 20) begin step(PIN_DN); k++; end
    k = 0; nr = 0;
    repeat (3) begin step(PIN_DN); k++; nr += o_release; end
    repeat (2) begin step(PIN_UP); k++; nr += o_release; end
    step(PIN_DN); k++;
    while (!o_long && k < 40) begin step(PIN_DN); k++; nr += o_release; end
    chk("glitch_long", k, 12);
    chk("glitch_rel", nr, 0);
    chk("glitch_level", o_level, 1);
    repeat (12) step(PIN_UP);

    // 256 clean presses wrap the counter
    do_reset();
    np = 0;
    for (int r = 0; r < 256; r++) begin
      repeat (8) begin step(PIN_DN); np += o_press; end
      repeat (8) step(PIN_UP);
    end
    chk("wrap_presses", np, 256);
    chk("wrap_count", o_count, 0);

    // reset mid PRESS_WAIT, button held through reset release
    repeat (8) step(PIN_DN);
    repeat (8) step(PIN_UP);
    chk("pre_rst_count", o_count, 1);
    repeat (4) step(PIN_DN);
    i_btn = PIN_DN;
    do_reset();
    k = 0;
    step(PIN_DN);
    while (!o_press && k < 20) begin step(PIN_DN); k++; end
    chk("held_rst_lat", k, 6);
    chk("held_rst_count", o_count, 1);
    repeat (10) step(PIN_UP);

    // randomized runs of bouncing / holding
    b = PIN_UP;
    for (int r = 0; r < 200; r++) begin
      b = ~b;
      len = (($urandom % 4) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 6);
      repeat (len) step(b);
    end
    repeat (20) step(PIN_UP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
